// File: rtl/norm_arb_pkg.sv
// rtl/norm_arb_pkg.sv - shared types and helpers for the normalizing shifter arbiter
//
// Purpose : field widths, request/response structs and the leading-zero
//           count used by the shared FP16 normalizing left shifter.
// Ports   : none (package).

package norm_arb_pkg;

  localparam int FRAC_W  = 13;
  localparam int EXP_W   = 5;
  localparam int SHIFT_W = 4;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } norm_req_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              zero;
    logic              uflow;
  } norm_rsp_t;

  // Number of zeros above the most significant set bit. An all-zero input
  // returns FRAC_W; callers treat zero fractions separately.
  function automatic logic [SHIFT_W-1:0] lead_zeros(input logic [FRAC_W-1:0] f);
    logic [SHIFT_W-1:0] n;
    logic               found;
    n     = '0;
    found = 1'b0;
    for (int i = FRAC_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with pointer-based priority
//
// Purpose : picks the first asserted request at or after ptr, wrapping from
//           N-1 back to 0. No grant is issued while en is low.
// Ports   : req   in  N      request vector
//           ptr   in  IDX_W  highest-priority index this cycle
//           en    in  1      arbitration enable
//           grant out N      one-hot grant (or zero)
//           idx   out IDX_W  encoded index of the granted lane
//           any   out 1      a grant was issued

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Rotate the search origin to ptr; N need not be a power of two.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_share_arbiter.sv
// rtl/norm_share_arbiter.sv - shares one FP16 normalizing shifter among MAC lanes
//
// Purpose : round-robin arbitrates lane requests, normalizes the winner's
//           fraction through a single combinational left shifter, adjusts its
//           exponent and returns the result through a registered valid/ready
//           stage tagged with the lane index.
// Ports   : CLK        in  1             clock
//           nRST       in  1             async active-low reset
//           req_valid  in  NUM_REQ       per-lane request valid
//           req_ready  out NUM_REQ       per-lane grant (one-hot or zero)
//           req_frac   in  NUM_REQ*13    lane i at [13i+12:13i]
//           req_exp    in  NUM_REQ*5     lane i at [5i+4:5i]
//           req_sign   in  NUM_REQ       per-lane sign
//           out_valid  out 1             result valid
//           out_ready  in  1             consumer accept
//           out_frac   out 13            normalized fraction
//           out_exp    out 5             adjusted exponent
//           out_sign   out 1             sign
//           out_id     out REQ_ID_W      producing lane
//           out_zero   out 1             input fraction was zero
//           out_uflow  out 1             exponent underflow

module norm_share_arbiter
  import norm_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FRAC_W-1:0]  req_frac,
  input  logic [NUM_REQ*EXP_W-1:0]   req_exp,
  input  logic [NUM_REQ-1:0]         req_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FRAC_W-1:0]          out_frac,
  output logic [EXP_W-1:0]           out_exp,
  output logic                       out_sign,
  output logic [REQ_ID_W-1:0]        out_id,
  output logic                       out_zero,
  output logic                       out_uflow
);

  norm_req_t             lanes [NUM_REQ];
  logic [REQ_ID_W-1:0]   rr_ptr;
  logic                  load_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [REQ_ID_W-1:0]   gnt_idx;
  logic                  gnt_any;
  logic                  xfer;

  norm_req_t             win;
  logic [SHIFT_W-1:0]    shift_amt;
  logic [FRAC_W-1:0]     shifted;
  norm_rsp_t             rsp_next;
  norm_rsp_t             rsp_q;
  logic [REQ_ID_W-1:0]   id_q;
  logic [REQ_ID_W-1:0]   ptr_next;

  // Unpack the flat lane buses into structs.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign lanes[i].sign = req_sign[i];
    assign lanes[i].exp  = req_exp[i*EXP_W +: EXP_W];
    assign lanes[i].frac = req_frac[i*FRAC_W +: FRAC_W];
  end

  // A slot is free when empty or when the held result retires this edge.
  assign load_en = !out_valid || out_ready;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (REQ_ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (load_en),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign req_ready = gnt;
  // The arbiter only grants asserted requests, so any grant is a transfer.
  assign xfer      = gnt_any;

  assign win = lanes[gnt_idx];

  // Shared normalizing shifter: one instance, driven by the winning lane.
  always_comb begin
    shift_amt = '0;
    if (win.frac != '0) shift_amt = lead_zeros(win.frac);
    shifted = win.frac << shift_amt;
  end

  // Exponent adjust. Underflow still returns the fully shifted fraction;
  // subnormal handling is left to the downstream rounder.
  always_comb begin
    rsp_next.sign  = win.sign;
    rsp_next.frac  = shifted;
    rsp_next.zero  = (win.frac == '0);
    rsp_next.exp   = '0;
    rsp_next.uflow = 1'b0;
    if (!rsp_next.zero) begin
      if (win.exp > {1'b0, shift_amt}) rsp_next.exp = win.exp - {1'b0, shift_amt};
      else                             rsp_next.uflow = 1'b1;
    end
  end

  assign ptr_next = (gnt_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      rsp_q     <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      rsp_q     <= rsp_next;
      id_q      <= gnt_idx;
      rr_ptr    <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_frac  = rsp_q.frac;
  assign out_exp   = rsp_q.exp;
  assign out_sign  = rsp_q.sign;
  assign out_zero  = rsp_q.zero;
  assign out_uflow = rsp_q.uflow;
  assign out_id    = id_q;

endmodule
